aes_inv_cipher: RTL and testbench



---
 rtl/aes_pkg.sv | 102 ++++++++++
 rtl/aes_key_expand_step.sv | 28 ++
 rtl/aes_inv_cipher.sv | 116 +++++++++++
 tb/tb_aes_inv_cipher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES tables, GF(2^8) helpers and the decryption FSM state type.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 09/0b/0d/0e are assembled from x2, x4 and x8 of each byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            a     = col[31 - 8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int j = 0; j < 4; j++) begin
            res[31 - 8*j -: 8] = me[j] ^ mb[(j + 1) % 4] ^ md[(j + 2) % 4] ^ m9[(j + 3) % 4];
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            res[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            res[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key schedule step: derives the next round key from the previous one.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_prev_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_next_o
);

    logic [31:0] w0, w1, w2, w3, subRot, n0, n1, n2, n3;

    assign w0 = rk_prev_i[127:96];
    assign w1 = rk_prev_i[95:64];
    assign w2 = rk_prev_i[63:32];
    assign w3 = rk_prev_i[31:0];

    // RotWord folded into the byte order of the SubWord lookup.
    assign subRot = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]}
                    ^ {rcon_i, 24'h000000};

    assign n0 = w0 ^ subRot;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: expands the key schedule, then runs one inverse round per clock.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    localparam logic [3:0] LAST = 4'(NR);

    state_e       state_q, state_d;
    logic         en_q;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] s_q, s_d;
    logic [127:0] dataOut_q, dataOut_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rkPrev, rkNext;
    logic         start;

    assign start  = AES_en & ~en_q & (state_q == IDLE);
    assign rkPrev = rk_q[cnt_q - 4'd1];

    aes_key_expand_step u_key_step (
        .rk_prev_i (rkPrev),
        .rcon_i    (RCON[cnt_q]),
        .rk_next_o (rkNext)
    );

    // Round keys are deliberately left unreset; they are rebuilt on every start.
    always_ff @(posedge AES_clk) begin
        if (start) begin
            rk_q[0] <= AES_key_in;
        end else if (state_q == KEYEXP) begin
            rk_q[cnt_q] <= rkNext;
        end
    end

    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            cnt_q     <= 4'd0;
            s_q       <= '0;
            dataOut_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= AES_en;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Busy drops one cycle after the valid pulse unless a new start lands on that same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        dataOut_d = dataOut_q;
        valid_d   = 1'b0;
        busy_d    = valid_q ? 1'b0 : busy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = AES_data_in;
                    cnt_d   = 4'd1;
                    busy_d  = 1'b1;
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    state_d = ADDKEY;
                end
            end
            ADDKEY: begin
                s_d     = s_q ^ rk_q[LAST];
                cnt_d   = LAST - 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                s_d   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_q[cnt_q]);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                dataOut_d = inv_sub_bytes(inv_shift_rows(s_q)) ^ rk_q[0];
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign AES_data_out       = dataOut_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed scoreboard bench for aes_inv_cipher: FIPS-197 vectors, encrypt loopback, churn, reset and back-to-back.
module tb_aes_inv_cipher;
    import aes_pkg::*;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] L_KEY = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    localparam logic [127:0] L_PT  = 128'h000000ab_00000000_00000000_00000000;

    logic         clk = 1'b0;
    logic         rstN;
    logic         en;
    logic [127:0] dataIn;
    logic [127:0] keyIn;
    logic [127:0] dataOut;
    logic         valid;
    logic         busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int validCount  = 0;
    logic [127:0] expQ [$];

    aes_inv_cipher #(.NR(10)) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rstN),
        .AES_en             (en),
        .AES_data_in        (dataIn),
        .AES_key_in         (keyIn),
        .AES_data_out       (dataOut),
        .AES_data_out_valid (valid),
        .AES_busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid) validCount++;
    end

    // Forward AES-128 reference used to produce the loopback ciphertext.
    function automatic logic [7:0] tbXt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] tbNextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        t = {SBOX[w[3][23:16]] ^ rc, SBOX[w[3][15:8]], SBOX[w[3][7:0]], SBOX[w[3][31:24]]};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] tbEncrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, t, k;
        logic [7:0]   rc, a0, a1, a2, a3;
        k  = key;
        rc = 8'h01;
        s  = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            k  = tbNextKey(k, rc);
            rc = tbXt(rc);
            for (int i = 0; i < 16; i++) s[8*i +: 8] = SBOX[s[8*i +: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
            s = t;
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];
                    a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];
                    a3 = s[103 - 32*c -: 8];
                    s[127 - 32*c -: 8] = tbXt(a0) ^ tbXt(a1) ^ a1 ^ a2 ^ a3;
                    s[119 - 32*c -: 8] = a0 ^ tbXt(a1) ^ tbXt(a2) ^ a2 ^ a3;
                    s[111 - 32*c -: 8] = a0 ^ a1 ^ tbXt(a2) ^ tbXt(a3) ^ a3;
                    s[103 - 32*c -: 8] = tbXt(a0) ^ a0 ^ a1 ^ a2 ^ tbXt(a3);
                end
            end
            s = s ^ k;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a start request at the current falling edge and queues the plaintext it should yield.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
        dataIn = ct;
        keyIn  = key;
        en     = 1'b1;
        expQ.push_back(pt);
    endtask

    // Waits (bounded) for the valid pulse; 'waited' counts falling edges already spent since applyStimulus.
    task automatic checkOutput(input string tag, input int waited);
        int cycles;
        logic [127:0] exp;
        cycles = waited;
        while (!valid && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        exp = (expQ.size() != 0) ? expQ.pop_front() : 128'hx;
        check({tag, " latency"}, 128'(cycles - 1), 128'd21);
        check({tag, " data"}, dataOut, exp);
        check({tag, " busy at valid"}, 128'(busy), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vc0;
        logic [127:0] lbCt;
        rstN = 1'b0; en = 1'b0; dataIn = '0; keyIn = '0;
        repeat (3) @(negedge clk);
        check("reset data_out", dataOut, 128'd0);
        check("reset valid", 128'(valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(B_CT, B_KEY, B_PT);
        @(negedge clk); en = 1'b0;
        checkOutput("appB", 1);
        @(negedge clk);
        check("appB valid drops", 128'(valid), 128'd0);
        check("appB busy drops", 128'(busy), 128'd0);
        check("appB data holds", dataOut, B_PT);

        applyStimulus(C_CT, C_KEY, C_PT);
        @(negedge clk); en = 1'b0;
        checkOutput("appC", 1);
        @(negedge clk);

        // Loopback with AES_en held high for 51 clocks: exactly one operation.
        lbCt = tbEncrypt(L_PT, L_KEY);
        vc0  = validCount;
        applyStimulus(lbCt, L_KEY, L_PT);
        checkOutput("loopback", 0);
        repeat (29) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("held en pulses", 128'(validCount - vc0), 128'd1);

        applyStimulus(B_CT, B_KEY, B_PT);
        @(negedge clk); en = 1'b0; dataIn = 128'ha6f2daeb_5e1c3f09_11223344_55667788; keyIn = C_KEY;
        @(negedge clk); dataIn = 128'hd7b26248_0a9c7e13_99aabbcc_ddeeff00;
        @(negedge clk); dataIn = 128'hf301a68a_47c2de55_0123abcd_fedc3210;
        checkOutput("churn", 3);
        @(negedge clk);

        // Reset lands on E8; AES_en is high when reset releases, so the first edge after is a start.
        vc0 = validCount;
        applyStimulus(C_CT, C_KEY, C_PT);
        @(negedge clk); en = 1'b0;
        repeat (7) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        check("midreset busy", 128'(busy), 128'd0);
        check("midreset valid", 128'(valid), 128'd0);
        check("midreset data_out", dataOut, 128'd0);
        void'(expQ.pop_back());
        applyStimulus(B_CT, B_KEY, B_PT);
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("restart", 0);
        en = 1'b0;
        @(negedge clk);
        check("midreset pulses", 128'(validCount - vc0), 128'd1);

        // Back-to-back: rising edge at E5 ignored, rising edge at E22 accepted.
        applyStimulus(C_CT, C_KEY, C_PT);
        @(negedge clk); en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        checkOutput("b2b first", 6);
        applyStimulus(B_CT, B_KEY, B_PT);
        @(negedge clk); en = 1'b0;
        check("b2b busy stays", 128'(busy), 128'd1);
        check("b2b hold early", dataOut, C_PT);
        repeat (10) @(negedge clk);
        check("b2b hold mid", dataOut, C_PT);
        checkOutput("b2b second", 11);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
